cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/ctrl_decode.sv | 52 +++++
 rtl/cpu_controller.sv | 126 ++++++++++++
 tb/tb_cpu_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-operation and controller-state encodings for the accumulator CPU.
// Used by both the datapath and the control FSM so the encodings cannot drift apart.
package cpu_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_STA = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_JMP = 8'h07;
  localparam logic [7:0] OP_JZ  = 8'h08;
  localparam logic [7:0] OP_MUL = 8'h09;
  localparam logic [7:0] OP_HLT = 8'hFF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, READ, EXEC, STORE, MSTART, MWAIT, MWB, HALT
  } state_t;

  typedef struct packed {
    logic       mux_pc;
    logic       mux_mar;
    logic       mux_acc;
    logic       mux_out;
    logic       load_pc;
    logic       load_mar;
    logic       load_mdr;
    logic       load_ir;
    logic       load_acc;
    logic [1:0] op_alu;
    logic       mult_ld;
    logic       mem_we;
  } ctrl_t;

  // Instructions whose operand is a memory address in IR[15:8].
  function automatic logic is_mem_op(input logic [7:0] op);
    return ((op >= OP_LDA) && (op <= OP_OR)) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: maps controller state + held opcode + registered zero flag to the control vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; never stalls.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t      state,
  input  logic [7:0]  opcode,
  input  logic        zflag,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH1: ctrl.load_mar = 1'b1;
      FETCH2: begin
        ctrl.load_mdr = 1'b1;
        ctrl.load_pc  = 1'b1;
      end
      FETCH3: ctrl.load_ir = 1'b1;
      DECODE: begin
        if (is_mem_op(opcode)) begin
          ctrl.load_mar = 1'b1;
          ctrl.mux_mar  = 1'b1;
        end else if ((opcode == OP_JMP) || ((opcode == OP_JZ) && zflag)) begin
          ctrl.load_pc = 1'b1;
          ctrl.mux_pc  = 1'b1;
        end
      end
      READ: ctrl.load_mdr = 1'b1;
      EXEC: begin
        ctrl.load_acc = 1'b1;
        case (opcode)
          OP_LDA:  ctrl.mux_acc = 1'b1;
          OP_SUB:  ctrl.op_alu  = ALU_SUB;
          OP_AND:  ctrl.op_alu  = ALU_AND;
          OP_OR:   ctrl.op_alu  = ALU_OR;
          default: ctrl.op_alu  = ALU_ADD;
        endcase
      end
      STORE:  ctrl.mem_we  = 1'b1;
      MSTART: ctrl.mult_ld = 1'b1;
      MWB: begin
        ctrl.load_acc = 1'b1;
        ctrl.mux_out  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Purpose: Moore control FSM for the accumulator CPU, including multiplier handshake and timeout.
// Latency: 4 (JMP/JZ/NOP), 5 (STA), 6 (LDA/ALU), 7+N (MUL) cycles per instruction.
// Backpressure: stalls only in MWAIT on mult_done, bounded by MULT_TIMEOUT cycles.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int MULT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  input  logic       zflag,
  input  logic       mult_done,
  output logic       muxPC,
  output logic       muxMAR,
  output logic       muxACC,
  output logic       muxOUT,
  output logic       loadPC,
  output logic       loadMAR,
  output logic       loadMDR,
  output logic       loadIR,
  output logic       loadACC,
  output logic [1:0] opALU,
  output logic       mult_ld,
  output logic       mem_we,
  output logic       halted,
  output logic       mult_err
);

  localparam int            CW     = $clog2(MULT_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO    = CW'(MULT_TIMEOUT);
  localparam logic [CW-1:0] TMO_M1 = CW'(MULT_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          z_q;
  logic          timeout;
  ctrl_t         ctrl;

  // zflag is registered so DECODE's JZ choice depends only on flops; ACC is
  // stable through FETCH1..FETCH3, so the sampled value is always current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH1;
      z_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      z_q   <= zflag;
    end
  end

  assign timeout = (state == MWAIT) && !mult_done && (wait_cnt == TMO_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == MSTART) begin
      wait_cnt <= '0;
    end else if ((state == MWAIT) && !mult_done && (wait_cnt != TMO)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_err <= 1'b0;
    end else if (timeout) begin
      mult_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH1: state_nxt = FETCH2;
      FETCH2: state_nxt = FETCH3;
      FETCH3: state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_HLT:                                     state_nxt = HALT;
          OP_STA:                                     state_nxt = STORE;
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: state_nxt = READ;
          OP_NOP, OP_JMP, OP_JZ:                      state_nxt = FETCH1;
          default:                                    state_nxt = FETCH1;
        endcase
      end
      READ:   state_nxt = (opcode == OP_MUL) ? MSTART : EXEC;
      EXEC:   state_nxt = FETCH1;
      STORE:  state_nxt = FETCH1;
      MSTART: state_nxt = MWAIT;
      MWAIT: begin
        if (mult_done)    state_nxt = MWB;
        else if (timeout) state_nxt = FETCH1;
        else              state_nxt = MWAIT;
      end
      MWB:     state_nxt = FETCH1;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH1;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .zflag  (z_q),
    .ctrl   (ctrl)
  );

  always_comb begin
    muxPC   = ctrl.mux_pc;
    muxMAR  = ctrl.mux_mar;
    muxACC  = ctrl.mux_acc;
    muxOUT  = ctrl.mux_out;
    loadPC  = ctrl.load_pc;
    loadMAR = ctrl.load_mar;
    loadMDR = ctrl.load_mdr;
    loadIR  = ctrl.load_ir;
    loadACC = ctrl.load_acc;
    opALU   = ctrl.op_alu;
    mult_ld = ctrl.mult_ld;
    mem_we  = ctrl.mem_we;
    halted  = (state == HALT);
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a small behavioural datapath, memory and multiplier run
// short programs; stores are scoreboarded against expected address/data/cycle.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  opcode;
  logic        zflag, mult_done;
  logic        muxPC, muxMAR, muxACC, muxOUT;
  logic        loadPC, loadMAR, loadMDR, loadIR, loadACC;
  logic [1:0]  opALU;
  logic        mult_ld, mem_we, halted, mult_err;

  cpu_controller #(.MULT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zflag(zflag), .mult_done(mult_done),
    .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC), .muxOUT(muxOUT),
    .loadPC(loadPC), .loadMAR(loadMAR), .loadMDR(loadMDR), .loadIR(loadIR), .loadACC(loadACC),
    .opALU(opALU), .mult_ld(mult_ld), .mem_we(mem_we), .halted(halted), .mult_err(mult_err)
  );

  always #5 clk = ~clk;

  logic [12:0] vec;
  assign vec = {muxPC, muxMAR, muxACC, muxOUT, loadPC, loadMAR, loadMDR, loadIR, loadACC,
                opALU, mult_ld, mem_we};
  localparam logic [12:0] V_FETCH1 = 13'h0080;

  // Behavioural datapath: 16-bit words {operand, opcode}, 256-word memory.
  logic [15:0] mem [0:255];
  logic [7:0]  pc, mar, mcnt, mult_lat;
  logic [15:0] mdr, ir, ma, mb, mres;
  logic [15:0] acc = 16'h0;
  logic        mbusy, mult_en;
  logic        poke;
  logic [7:0]  poke_a;
  logic [15:0] poke_d;

  assign opcode    = ir[7:0];
  assign zflag     = (acc == 16'h0);
  assign mres      = ma * mb;
  assign mult_done = mult_en && mbusy && (mcnt == 8'd0);

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   alu = a + b;
      2'b01:   alu = a - b;
      2'b10:   alu = a & b;
      default: alu = a | b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pc <= 8'h0; mar <= 8'h0; mdr <= 16'h0; ir <= 16'h0;
      mbusy <= 1'b0; mcnt <= 8'h0; ma <= 16'h0; mb <= 16'h0;
      if (poke) mem[poke_a] <= poke_d;
    end else begin
      if (loadMAR) mar <= muxMAR ? ir[15:8] : pc;
      if (loadMDR) mdr <= mem[mar];
      if (loadPC)  pc  <= muxPC ? ir[15:8] : pc + 8'd1;
      if (loadIR)  ir  <= mdr;
      if (loadACC) acc <= muxOUT ? mres : (muxACC ? mdr : alu(opALU, acc, mdr));
      if (mem_we)  mem[mar] <= acc;
      if (mult_ld) begin
        mbusy <= 1'b1; mcnt <= mult_lat - 8'd1; ma <= acc; mb <= mdr;
      end else if (mbusy && (mcnt != 8'd0)) begin
        mcnt <= mcnt - 8'd1;
      end else if (mult_done) begin
        mbusy <= 1'b0;
      end
    end
  end

  // Cycle 1 is the FETCH1 right after reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Observed-event monitor.
  logic [7:0]  st_a[$];
  logic [15:0] st_d[$];
  int          st_c[$];
  int          ld_cnt = 0;
  int          err_cyc = 0;
  logic        err_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        st_a.push_back(mar); st_d.push_back(acc); st_c.push_back(cyc + 1);
      end
      if (mult_ld) ld_cnt++;
      if (mult_err && !err_prev) err_cyc = cyc + 1;
    end
    err_prev = mult_err;
  end

  // Scoreboard of expected stores, filled as each program is loaded.
  logic [7:0]  ex_a[$];
  logic [15:0] ex_d[$];
  int          ex_c[$];
  int          rd_idx = 0;
  int          total = 0;
  int          bad = 0;
  int          ld0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_store(input logic [7:0] a, input logic [15:0] d, input int c);
    ex_a.push_back(a); ex_d.push_back(d); ex_c.push_back(c);
  endtask

  task automatic check_stores(input string tag);
    while (ex_a.size() != 0) begin
      chk({tag, "_store_present"}, 32'(st_a.size() > rd_idx), 32'(1));
      if (st_a.size() > rd_idx) begin
        chk({tag, "_store_addr"},  32'(st_a[rd_idx]), 32'(ex_a[0]));
        chk({tag, "_store_data"},  32'(st_d[rd_idx]), 32'(ex_d[0]));
        chk({tag, "_store_cycle"}, 32'(st_c[rd_idx]), 32'(ex_c[0]));
        rd_idx++;
      end
      void'(ex_a.pop_front()); void'(ex_d.pop_front()); void'(ex_c.pop_front());
    end
    chk({tag, "_no_extra_store"}, 32'(st_a.size()), 32'(rd_idx));
    rd_idx = st_a.size();
  endtask

  task automatic start_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    chk({tag, "_rst_vec"},      32'(vec),      32'(V_FETCH1));
    chk({tag, "_rst_halted"},   32'(halted),   32'(0));
    chk({tag, "_rst_mult_err"}, 32'(mult_err), 32'(0));
  endtask

  task automatic poke_w(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached_halt"}, 32'(halted), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    poke = 1'b0; poke_a = 8'h0; poke_d = 16'h0;
    mult_en = 1'b1; mult_lat = 8'd3;

    // LDA/ADD/STA: 3+4 stored at 12h on cycle 17.
    start_reset("t1");
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h1103); poke_w(8'h02, 16'h1202);
    poke_w(8'h03, 16'h00FF); poke_w(8'h10, 16'd3);    poke_w(8'h11, 16'd4);
    expect_store(8'h12, 16'd7, 17);
    release_rst();
    run_until_halt("t1", 80);
    check_stores("t1");
    chk("t1_mem12", 32'(mem[8'h12]), 32'd7);

    // SUB/AND/OR select the right opALU codes.
    start_reset("t1b");
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h1104); poke_w(8'h02, 16'h2002);
    poke_w(8'h03, 16'h1205); poke_w(8'h04, 16'h2102); poke_w(8'h05, 16'h1306);
    poke_w(8'h06, 16'h2202); poke_w(8'h07, 16'h00FF);
    poke_w(8'h10, 16'h000C); poke_w(8'h11, 16'h0005); poke_w(8'h12, 16'h000A); poke_w(8'h13, 16'h0011);
    expect_store(8'h20, 16'h0007, 17);
    expect_store(8'h21, 16'h0002, 28);
    expect_store(8'h22, 16'h0013, 39);
    release_rst();
    run_until_halt("t1b", 120);
    check_stores("t1b");

    // JZ taken with ACC=0, then NOP and JMP (4 cycles each).
    start_reset("t2a");
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h2008); poke_w(8'h02, 16'h3002); poke_w(8'h03, 16'h00FF);
    poke_w(8'h20, 16'h0000); poke_w(8'h21, 16'h2507); poke_w(8'h22, 16'h3202);
    poke_w(8'h25, 16'h3102); poke_w(8'h26, 16'h00FF); poke_w(8'h10, 16'h0000);
    expect_store(8'h31, 16'h0000, 23);
    release_rst();
    run_until_halt("t2a", 80);
    check_stores("t2a");

    // JZ not taken with ACC=5 falls through to PC+1.
    start_reset("t2b");
    poke_w(8'h10, 16'h0005);
    expect_store(8'h30, 16'h0005, 15);
    release_rst();
    run_until_halt("t2b", 80);
    check_stores("t2b");

    // MUL 7*6 with mult_done after 3 MWAIT cycles.
    start_reset("t3");
    mult_en = 1'b1;
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h3009); poke_w(8'h02, 16'h4002); poke_w(8'h03, 16'h00FF);
    poke_w(8'h10, 16'h0007); poke_w(8'h30, 16'h0006);
    expect_store(8'h40, 16'd42, 21);
    ld0 = ld_cnt;
    release_rst();
    run_until_halt("t3", 80);
    check_stores("t3");
    chk("t3_mult_ld_pulses", 32'(ld_cnt - ld0), 32'd1);
    chk("t3_mult_err", 32'(mult_err), 32'd0);

    // Reset asserted while waiting in MWAIT aborts the MUL.
    start_reset("t4");
    mult_en = 1'b0;
    poke_w(8'h00, 16'h3009);
    release_rst();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mult_ld) break;
    end
    chk("t4_mult_ld_seen", 32'(mult_ld), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_mwait_idle", 32'(vec), 32'(0));
    #2 rst = 1'b1;
    #1 chk("t4_async_rst_vec", 32'(vec), 32'(V_FETCH1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_rst_hold_vec", 32'(vec), 32'(V_FETCH1));
    end
    check_stores("t4");

    // MUL timeout: 15 MWAIT cycles, mult_err from cycle 28, ACC kept.
    start_reset("t5");
    mult_en = 1'b0;
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h3009); poke_w(8'h02, 16'h4002); poke_w(8'h03, 16'h00FF);
    poke_w(8'h10, 16'h0007); poke_w(8'h30, 16'h0006);
    expect_store(8'h40, 16'h0007, 32);
    ld0 = ld_cnt;
    release_rst();
    run_until_halt("t5", 100);
    check_stores("t5");
    chk("t5_mult_err_sticky", 32'(mult_err), 32'd1);
    chk("t5_mult_err_cycle", 32'(err_cyc), 32'd28);
    chk("t5_mult_ld_pulses", 32'(ld_cnt - ld0), 32'd1);

    // Reset asserted during STORE suppresses the write.
    start_reset("t6");
    poke_w(8'h00, 16'h6002);
    release_rst();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc == 3) break;
    end
    @(posedge clk);
    #1 chk("t6_store_entered", 32'(mem_we), 32'd1);
    #1 rst = 1'b1;
    #1 chk("t6_async_rst_vec", 32'(vec), 32'(V_FETCH1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rst_hold_vec", 32'(vec), 32'(V_FETCH1));
    end
    check_stores("t6");

    // Undefined opcode 7Ah acts as NOP; HLT then holds with no loads.
    start_reset("t7");
    poke_w(8'h00, 16'h1001); poke_w(8'h01, 16'h007A); poke_w(8'h02, 16'h5002); poke_w(8'h03, 16'h00FF);
    poke_w(8'h10, 16'h0009);
    expect_store(8'h50, 16'h0009, 15);
    release_rst();
    run_until_halt("t7", 80);
    check_stores("t7");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t7_halt_hold", 32'({vec, halted}), 32'({13'h0, 1'b1}));
    end

    start_reset("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
